// File: rtl/ratmaze_pkg.sv
// rtl/ratmaze_pkg.sv - shared rat-in-maze types, direction codes and location helpers
// Purpose : constants and helpers shared by the maze solver and the path replayer.
// Contents: LOC_W / HALF_W location geometry, DIR_* move codes, replayer state
//           encoding, loc_row / loc_col field extractors.
package ratmaze_pkg;

    localparam int LOC_W  = 8;
    localparam int HALF_W = LOC_W / 2;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        PR_IDLE = 3'd0,
        PR_RD   = 3'd1,
        PR_LAT  = 3'd2,
        PR_EMIT = 3'd3,
        PR_DONE = 3'd4
    } pr_state_t;

    function automatic logic [HALF_W-1:0] loc_row(input logic [LOC_W-1:0] l);
        return l[LOC_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] loc_col(input logic [LOC_W-1:0] l);
        return l[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/loc_step_decoder.sv
// rtl/loc_step_decoder.sv - combinational (prev, curr) cell pair to move direction and adjacency
// Purpose : decode the move between two maze cells; shared with the solver datapath.
// Ports   : i_prev  in  LOC_W  source cell {row, col}
//           i_curr  in  LOC_W  destination cell {row, col}
//           o_dir   out 2      row change wins over column change; same cell gives DIR_UP
//           o_adj   out 1      1 when the cells are exactly one orthogonal step apart
module loc_step_decoder
    import ratmaze_pkg::*;
(
    input  logic [LOC_W-1:0] i_prev,
    input  logic [LOC_W-1:0] i_curr,
    output logic [1:0]       o_dir,
    output logic             o_adj
);

    logic [HALF_W-1:0] w_pr;
    logic [HALF_W-1:0] w_pc;
    logic [HALF_W-1:0] w_cr;
    logic [HALF_W-1:0] w_cc;
    logic              w_row_step;
    logic              w_col_step;

    localparam logic [HALF_W:0] STEP_ONE = {{HALF_W{1'b0}}, 1'b1};

    assign w_pr = loc_row(i_prev);
    assign w_pc = loc_col(i_prev);
    assign w_cr = loc_row(i_curr);
    assign w_cc = loc_col(i_curr);

    // One extra bit so the grid edges (0 and all-ones) never look like neighbours.
    assign w_row_step = ({1'b0, w_cr} == ({1'b0, w_pr} + STEP_ONE)) ||
                        ({1'b0, w_pr} == ({1'b0, w_cr} + STEP_ONE));
    assign w_col_step = ({1'b0, w_cc} == ({1'b0, w_pc} + STEP_ONE)) ||
                        ({1'b0, w_pc} == ({1'b0, w_cc} + STEP_ONE));

    assign o_adj = ((w_cr == w_pr) && w_col_step) || ((w_cc == w_pc) && w_row_step);

    always_comb begin
        o_dir = DIR_UP;
        if (w_cr < w_pr) begin
            o_dir = DIR_UP;
        end else if (w_cr > w_pr) begin
            o_dir = DIR_DOWN;
        end else if (w_cc > w_pc) begin
            o_dir = DIR_RIGHT;
        end else if (w_cc < w_pc) begin
            o_dir = DIR_LEFT;
        end
    end

endmodule

// File: rtl/path_replayer.sv
// rtl/path_replayer.sv - replays the solver path store bottom-to-top as a stream of moves
// Purpose : after a solve, read the path store from start cell to goal cell and emit one
//           move beat (destination cell + direction) per adjacent pair over valid/ready.
// Option  : PATH_CHECK_EN - when defined, a non-adjacent cell pair sets sticky err and ends
//           the replay without emitting that beat; when undefined err is tied to 0.
// Ports   : clk, rst (sync, active high); run starts a replay from IDLE or DONE;
//           pathLen entry count, clamped to 2**ADDR_W and latched on an accepted run;
//           memRd/memAddr read port, memData returns one cycle after memRd;
//           valid/ready/loc/dir move stream; move pulses on each accepted beat;
//           done held until the next accepted run; err sticky non-adjacency flag.
module path_replayer #(
    parameter int ADDR_W = 8,
    parameter int LOC_W  = ratmaze_pkg::LOC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W:0]   pathLen,
    output logic              memRd,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [LOC_W-1:0]  memData,
    output logic              valid,
    input  logic              ready,
    output logic [LOC_W-1:0]  loc,
    output logic [1:0]        dir,
    output logic              move,
    output logic              done,
    output logic              err
);

    import ratmaze_pkg::*;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] IDX_TWO = {{(ADDR_W-1){1'b0}}, 2'b10};

    pr_state_t        r_state;
    pr_state_t        w_next;
    logic [ADDR_W:0]  r_len;
    logic [ADDR_W:0]  r_idx;
    logic [LOC_W-1:0] r_prev;
    logic [LOC_W-1:0] r_curr;
    logic [1:0]       r_dir;

    logic [ADDR_W:0]  w_len_clamped;
    logic             w_last;
    logic [1:0]       w_dir;
    logic             w_adj;
    logic             w_valid;
    logic             w_rd;
    logic             w_move;
    logic             w_done;
    logic             w_pair_ok;

    assign w_len_clamped = (pathLen > MAX_LEN) ? MAX_LEN : pathLen;
    // Only evaluated in EMIT, where r_len >= 2, so the subtraction never underflows.
    assign w_last        = (r_idx == (r_len - IDX_ONE));

    // Decodes against memData directly so dir is ready at the end of LAT.
    loc_step_decoder u_step (
        .i_prev (r_prev),
        .i_curr (memData),
        .o_dir  (w_dir),
        .o_adj  (w_adj)
    );

`ifdef PATH_CHECK_EN
    logic r_err;
    assign w_pair_ok = w_adj;
    assign err       = r_err;
`else
    logic w_unused_adj;
    assign w_unused_adj = w_adj;
    assign w_pair_ok    = 1'b1;
    assign err          = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_rd    = 1'b0;
        w_move  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            PR_IDLE, PR_DONE: begin
                w_done = (r_state == PR_DONE);
                if (run) begin
                    w_next = (w_len_clamped < IDX_TWO) ? PR_DONE : PR_RD;
                end
            end
            PR_RD: begin
                w_rd   = 1'b1;
                w_next = PR_LAT;
            end
            PR_LAT: begin
                if (r_idx == '0) begin
                    w_next = PR_RD;
                end else begin
                    w_next = w_pair_ok ? PR_EMIT : PR_DONE;
                end
            end
            PR_EMIT: begin
                w_valid = 1'b1;
                if (ready) begin
                    w_move = 1'b1;
                    w_next = w_last ? PR_DONE : PR_RD;
                end
            end
            default: w_next = PR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PR_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_prev  <= '0;
            r_curr  <= '0;
            r_dir   <= DIR_UP;
`ifdef PATH_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                PR_IDLE, PR_DONE: begin
                    if (run) begin
                        r_len <= w_len_clamped;
                        r_idx <= '0;
`ifdef PATH_CHECK_EN
                        r_err <= 1'b0;
`endif
                    end
                end
                PR_LAT: begin
                    if (r_idx == '0) begin
                        r_prev <= memData;
                        r_idx  <= IDX_ONE;
                    end else if (w_pair_ok) begin
                        r_curr <= memData;
                        r_dir  <= w_dir;
                    end else begin
`ifdef PATH_CHECK_EN
                        r_err  <= 1'b1;
`endif
                    end
                end
                PR_EMIT: begin
                    if (ready) begin
                        r_prev <= r_curr;
                        if (!w_last) begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign memRd   = w_rd;
    assign memAddr = r_idx[ADDR_W-1:0];
    assign valid   = w_valid;
    assign move    = w_move;
    assign done    = w_done;
    assign loc     = r_curr;
    assign dir     = r_dir;

endmodule
